// File: rtl/stream_counter_fsm.sv
// rtl/stream_counter_fsm.sv - strided BRAM address stream generator with multi-pass looping and abort
//
// Purpose:
//   Owns a beat counter and a pass counter and issues one BRAM address per
//   accepted beat on a valid/ready handshake. A run is cnt_val beats per pass
//   times max(loop,1) passes. Every pass restarts at base and advances by
//   stride per beat, wrapping mod 2^ADDR_BIT. A run can be cut short with abort_i.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start_i      start request, sampled only in IDLE
//   cnt_val_i    beats per pass, captured on accepted start
//   base_addr_i  first address of each pass, captured on accepted start
//   stride_i     address increment per beat, captured on accepted start
//   loop_i       number of passes (0 behaves as 1), captured on accepted start
//   abort_i      ends the run early, effective only in RUN
//   ready_i      downstream accepts the current beat
//   idle_o       state is IDLE
//   run_o        state is RUN
//   done_o       one-cycle pulse in the DONE state
//   aborted_o    asserted with done_o when the run ended by abort
//   valid_o      current beat is valid
//   last_o       current beat is the final beat of the final pass
//   addr_o       current beat address
//   cnt_o        beat index within the current pass
//   loop_o       current pass index

module stream_counter_fsm #(
    parameter int CNT_BIT  = 31,
    parameter int ADDR_BIT = 12,
    parameter int LOOP_BIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [CNT_BIT-1:0]  cnt_val_i,
    input  logic [ADDR_BIT-1:0] base_addr_i,
    input  logic [ADDR_BIT-1:0] stride_i,
    input  logic [LOOP_BIT-1:0] loop_i,
    input  logic                abort_i,
    input  logic                ready_i,
    output logic                idle_o,
    output logic                run_o,
    output logic                done_o,
    output logic                aborted_o,
    output logic                valid_o,
    output logic                last_o,
    output logic [ADDR_BIT-1:0] addr_o,
    output logic [CNT_BIT-1:0]  cnt_o,
    output logic [LOOP_BIT-1:0] loop_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_BIT-1:0]  CNT_ONE  = {{(CNT_BIT-1){1'b0}}, 1'b1};
    localparam logic [LOOP_BIT-1:0] LOOP_ONE = {{(LOOP_BIT-1){1'b0}}, 1'b1};

    state_t              state;

    // Configuration captured on an accepted start, frozen for the whole run.
    logic [CNT_BIT-1:0]  cnt_val_r;
    logic [ADDR_BIT-1:0] base_r;
    logic [ADDR_BIT-1:0] stride_r;
    // Index of the final pass, i.e. max(loop_i,1)-1. Precomputed at start so
    // the run-time comparison is a plain equality.
    logic [LOOP_BIT-1:0] loop_last_r;

    logic [CNT_BIT-1:0]  cnt_last;
    logic                beat_last;
    logic                pass_last;

    // cnt_val_r is never zero while in RUN, so the subtraction cannot wrap
    // where it matters. In other states last_o is masked by valid_o.
    assign cnt_last  = cnt_val_r - CNT_ONE;
    assign beat_last = (cnt_o == cnt_last);
    assign pass_last = (loop_o == loop_last_r);
    assign last_o    = valid_o & beat_last & pass_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt_val_r   <= '0;
            base_r      <= '0;
            stride_r    <= '0;
            loop_last_r <= '0;
            addr_o      <= '0;
            cnt_o       <= '0;
            loop_o      <= '0;
            idle_o      <= 1'b1;
            run_o       <= 1'b0;
            done_o      <= 1'b0;
            aborted_o   <= 1'b0;
            valid_o     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_o    <= 1'b0;
                    aborted_o <= 1'b0;
                    if (start_i) begin
                        if (cnt_val_i != '0) begin
                            cnt_val_r   <= cnt_val_i;
                            base_r      <= base_addr_i;
                            stride_r    <= stride_i;
                            loop_last_r <= (loop_i == '0) ? '0 : (loop_i - LOOP_ONE);
                            // First beat is presented in the very first RUN cycle.
                            addr_o      <= base_addr_i;
                            cnt_o       <= '0;
                            loop_o      <= '0;
                            state       <= S_RUN;
                            idle_o      <= 1'b0;
                            run_o       <= 1'b1;
                            valid_o     <= 1'b1;
                        end else begin
                            // Empty run: straight to DONE, no beats issued,
                            // position registers keep their previous values.
                            state       <= S_DONE;
                            idle_o      <= 1'b0;
                            done_o      <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (abort_i) begin
                        // Abort wins over a coincident transfer: the beat on
                        // the bus is not counted and the position holds.
                        state     <= S_DONE;
                        run_o     <= 1'b0;
                        valid_o   <= 1'b0;
                        done_o    <= 1'b1;
                        aborted_o <= 1'b1;
                    end else if (ready_i) begin
                        if (beat_last) begin
                            if (pass_last) begin
                                state     <= S_DONE;
                                run_o     <= 1'b0;
                                valid_o   <= 1'b0;
                                done_o    <= 1'b1;
                                aborted_o <= 1'b0;
                            end else begin
                                // Pass boundary: rewind with no bubble.
                                cnt_o  <= '0;
                                addr_o <= base_r;
                                loop_o <= loop_o + LOOP_ONE;
                            end
                        end else begin
                            cnt_o  <= cnt_o + CNT_ONE;
                            addr_o <= addr_o + stride_r;
                        end
                    end
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    idle_o    <= 1'b1;
                    done_o    <= 1'b0;
                    aborted_o <= 1'b0;
                end

                default: begin
                    state     <= S_IDLE;
                    idle_o    <= 1'b1;
                    run_o     <= 1'b0;
                    done_o    <= 1'b0;
                    aborted_o <= 1'b0;
                    valid_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_counter_fsm.sv
// tb/tb_stream_counter_fsm.sv - self-checking bench for stream_counter_fsm

module tb_stream_counter_fsm;

    localparam int CB = 31;
    localparam int AB = 12;
    localparam int LB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [CB-1:0] cnt_val_i;
    logic [AB-1:0] base_addr_i;
    logic [AB-1:0] stride_i;
    logic [LB-1:0] loop_i;
    logic          abort_i;
    logic          ready_i;
    logic          idle_o, run_o, done_o, aborted_o, valid_o, last_o;
    logic [AB-1:0] addr_o;
    logic [CB-1:0] cnt_o;
    logic [LB-1:0] loop_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    stream_counter_fsm #(.CNT_BIT(CB), .ADDR_BIT(AB), .LOOP_BIT(LB)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .cnt_val_i(cnt_val_i),
        .base_addr_i(base_addr_i), .stride_i(stride_i), .loop_i(loop_i),
        .abort_i(abort_i), .ready_i(ready_i), .idle_o(idle_o), .run_o(run_o),
        .done_o(done_o), .aborted_o(aborted_o), .valid_o(valid_o), .last_o(last_o),
        .addr_o(addr_o), .cnt_o(cnt_o), .loop_o(loop_o)
    );

    // Reference beat list for one run, built from the closed-form rule
    // addr = base + beat*stride (mod 2^AB) over every (pass, beat) pair.
    logic [AB-1:0] e_addr[$];
    logic [CB-1:0] e_cnt[$];
    logic [LB-1:0] e_loop[$];
    logic          e_last[$];

    task automatic build_model(input int cv, input int ba, input int st, input int lp);
        int np;
        e_addr.delete(); e_cnt.delete(); e_loop.delete(); e_last.delete();
        np = (lp == 0) ? 1 : lp;
        for (int p = 0; p < np; p++) begin
            for (int b = 0; b < cv; b++) begin
                e_addr.push_back(AB'((ba + b * st) % (1 << AB)));
                e_cnt.push_back(CB'(b));
                e_loop.push_back(LB'(p));
                e_last.push_back((p == np - 1) && (b == cv - 1));
            end
        end
    endtask

    // One run: ready_pct is the chance of ready_i per cycle, abort_beat is the
    // beat index at which abort_i is raised (-1 for none).
    task automatic do_run(input string nm, input int cv, input int ba, input int st,
                          input int lp, input int ready_pct, input int abort_beat);
        int  idx, cycles, total, exp_x, fin;
        bit  finished, aborting;
        build_model(cv, ba, st, lp);
        total    = e_addr.size();
        exp_x    = (abort_beat >= 0 && abort_beat < total) ? abort_beat : total;
        idx      = 0;
        cycles   = 0;
        finished = 0;
        aborting = 0;
        @(negedge clk);
        start_i = 1'b1; cnt_val_i = CB'(cv); base_addr_i = AB'(ba);
        stride_i = AB'(st); loop_i = LB'(lp); abort_i = 1'b0; ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        // Config changes after the start must not affect the run.
        cnt_val_i = CB'($urandom_range(9)); base_addr_i = AB'($urandom);
        stride_i = AB'($urandom); loop_i = LB'($urandom_range(5));
        while (!finished && cycles < 2000) begin
            if (done_o) begin
                finished = 1;
                n_chk++; if (idx !== exp_x) $display("FAIL %s transfers: got %0d want %0d", nm, idx, exp_x); else n_pass++;
                n_chk++; if (valid_o !== 1'b0) $display("FAIL %s done_valid: got %b want 0", nm, valid_o); else n_pass++;
                n_chk++; if (aborted_o !== (exp_x != total)) $display("FAIL %s aborted: got %b want %b", nm, aborted_o, exp_x != total); else n_pass++;
                if (total > 0) begin
                    fin = (exp_x != total) ? exp_x : total - 1;
                    n_chk++; if (addr_o !== e_addr[fin] || cnt_o !== e_cnt[fin] || loop_o !== e_loop[fin])
                        $display("FAIL %s final_hold: got a=%h c=%0d l=%0d want a=%h c=%0d l=%0d",
                                 nm, addr_o, cnt_o, loop_o, e_addr[fin], e_cnt[fin], e_loop[fin]);
                    else n_pass++;
                end
                // A start during DONE must not be accepted.
                start_i = 1'b1; cnt_val_i = 5; abort_i = 1'b0; ready_i = 1'b0;
            end else begin
                n_chk++;
                if (aborting || idx >= total || valid_o !== 1'b1 || run_o !== 1'b1) begin
                    $display("FAIL %s beat_valid: idx=%0d valid=%b run=%b total=%0d", nm, idx, valid_o, run_o, total);
                    finished = 1;
                end else begin
                    n_pass++;
                    n_chk++; if (addr_o !== e_addr[idx]) $display("FAIL %s addr[%0d]: got %h want %h", nm, idx, addr_o, e_addr[idx]); else n_pass++;
                    n_chk++; if (cnt_o !== e_cnt[idx]) $display("FAIL %s cnt[%0d]: got %0d want %0d", nm, idx, cnt_o, e_cnt[idx]); else n_pass++;
                    n_chk++; if (loop_o !== e_loop[idx]) $display("FAIL %s loop[%0d]: got %0d want %0d", nm, idx, loop_o, e_loop[idx]); else n_pass++;
                    n_chk++; if (last_o !== e_last[idx]) $display("FAIL %s last[%0d]: got %b want %b", nm, idx, last_o, e_last[idx]); else n_pass++;
                    ready_i = ($urandom_range(99) < ready_pct);
                    start_i = $urandom_range(1);
                    if (idx == abort_beat) begin
                        abort_i  = 1'b1;
                        aborting = 1;
                    end else if (ready_i) begin
                        idx++;
                    end
                end
            end
            @(negedge clk);
            cycles++;
        end
        if (!finished) begin
            n_chk++;
            $display("FAIL %s timeout: got no done_o want done_o", nm);
        end
        start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b0;
        n_chk++; if (idle_o !== 1'b1 || run_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL %s post_idle: got idle=%b run=%b done=%b want 1 0 0", nm, idle_o, run_o, done_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_i = 0; cnt_val_i = 0; base_addr_i = 0; stride_i = 0;
        loop_i = 0; abort_i = 0; ready_i = 0;
        repeat (2) @(negedge clk);
        n_chk++; if ({idle_o, run_o, done_o, aborted_o, valid_o, last_o} !== 6'b100000)
            $display("FAIL reset_flags: got %b want 100000", {idle_o, run_o, done_o, aborted_o, valid_o, last_o});
        else n_pass++;
        n_chk++; if (addr_o !== '0 || cnt_o !== '0 || loop_o !== '0)
            $display("FAIL reset_pos: got a=%h c=%0d l=%0d want 0", addr_o, cnt_o, loop_o);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        start_i = 1; cnt_val_i = 8; base_addr_i = 12'h123; stride_i = 3; loop_i = 1; ready_i = 1;
        @(negedge clk);
        start_i = 0;
        repeat (3) @(negedge clk);
        n_chk++; if (cnt_o !== 3) $display("FAIL midrun_pre: got cnt %0d want 3", cnt_o); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; ready_i = 0;
        n_chk++; if ({idle_o, run_o, done_o, valid_o} !== 4'b1000 || addr_o !== '0 || cnt_o !== '0 || loop_o !== '0)
            $display("FAIL midrun_reset: got flags=%b a=%h c=%0d l=%0d want 1000 0 0 0",
                     {idle_o, run_o, done_o, valid_o}, addr_o, cnt_o, loop_o);
        else n_pass++;
        @(negedge clk);
        n_chk++; if (done_o !== 1'b0 || idle_o !== 1'b1) $display("FAIL midrun_nodone: got done=%b idle=%b want 0 1", done_o, idle_o); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            do_run("random", $urandom_range(1, 6), $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(30, 100), ($urandom_range(3) == 0) ? $urandom_range(0, 8) : -1);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        do_run("basic", 4, 'h010, 1, 1, 100, -1);
        do_run("backpressure", 3, 0, 2, 1, 50, -1);
        do_run("loop_wrap", 3, 'hFFE, 1, 2, 100, -1);
        do_run("zero_cnt", 0, 'h055, 1, 1, 100, -1);
        do_run("zero_loop", 2, 'h100, 4, 0, 100, -1);
        do_run("abort", 5, 'h020, 1, 1, 100, 2);
        do_run("abort_first", 3, 'h7FF, 5, 3, 60, 0);
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stream_counter_fsm.md
Name: stream_counter_fsm

Overview:
Parametrised successor to the single-shot run counter FSM used by the BRAM accessor. It owns its beat counter and generates a strided BRAM address stream with a valid/ready handshake. It supports multi-pass looping and an abort. It sits between the accessor control registers (start, length, base, stride, loops) and the BRAM read/write port.

Parameters:
CNT_BIT, 31, width of beat count (cnt_val_i, cnt_o)
ADDR_BIT, 12, width of BRAM address (base_addr_i, stride_i, addr_o)
LOOP_BIT, 8, width of pass count (loop_i, loop_o)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start_i  input  1  start request; sampled only in IDLE
cnt_val_i  input  CNT_BIT  beats per pass; captured on accepted start
base_addr_i  input  ADDR_BIT  first address of each pass; captured on accepted start
stride_i  input  ADDR_BIT  address increment per beat; captured on accepted start
loop_i  input  LOOP_BIT  number of passes; 0 treated as 1; captured on accepted start
abort_i  input  1  terminate the run early; effective only in RUN
ready_i  input  1  downstream accepts the current beat
idle_o  output  1  state == IDLE
run_o  output  1  state == RUN
done_o  output  1  single-cycle pulse, state == DONE
aborted_o  output  1  high with done_o when the run ended by abort
valid_o  output  1  current beat valid
last_o  output  1  current beat is the final beat of the final pass
addr_o  output  ADDR_BIT  current beat address
cnt_o  output  CNT_BIT  beat index within the current pass
loop_o  output  LOOP_BIT  current pass index

Behaviour:
- Reset: state IDLE, all outputs 0 except idle_o=1. All captured registers are 0. Reset mid-run returns to IDLE on the next edge with no done_o.
- States are IDLE, RUN and DONE, all registered.
- IDLE:
  - start_i=1 and cnt_val_i!=0: capture config and go to RUN. In the first RUN cycle, valid_o=1, addr_o=base, cnt_o=0, loop_o=0 (latency 1 cycle from start).
  - start_i=1 and cnt_val_i==0: go to DONE. No beats are issued, aborted_o=0.
- RUN:
  - valid_o=1 for the whole state.
  - A transfer occurs on a cycle with valid_o & ready_i.
  - Without a transfer, addr_o, cnt_o and loop_o hold. This is a stall of any length.
  - Transfer, not the last beat of the pass: cnt_o+1; addr_o+stride, truncated to ADDR_BIT (wraps mod 2^ADDR_BIT).
  - Transfer on the last beat of the pass (cnt_o == cnt_val-1), not the last pass: cnt_o=0, addr_o=base, loop_o+1. No bubble; valid_o stays high.
  - Transfer on the last beat of the last pass (loop_o == max(loop_i,1)-1): go to DONE.
  - last_o = valid_o & (cnt_o == cnt_val-1) & last pass. It is combinational from registered state.
  - abort_i=1: go to DONE with aborted_o=1. abort_i has priority over a simultaneous transfer; that beat is counted as not accepted.
  - start_i is ignored.
- DONE:
  - Lasts exactly one cycle with done_o=1 and valid_o=0, then returns to IDLE.
  - addr_o, cnt_o and loop_o hold their final values until the next accepted start.
  - start_i and abort_i are ignored.
- A start asserted in the DONE cycle is not accepted. The minimum gap between runs is 1 IDLE cycle.
- Total beats per run = cnt_val × max(loop_i,1). Config input changes during RUN have no effect.
- All arithmetic is unsigned. cnt_val-1 is evaluated only when cnt_val != 0.

Test Plan:
- Basic run: cnt_val=4, base=0x010, stride=1, loop=1, ready_i=1 -> addrs 0x010..0x013 on 4 consecutive cycles, last_o on the 4th, done_o 1 cycle later, then idle_o.
- Backpressure: cnt_val=3, stride=2, ready_i toggling 1,0,0,1,0,1 -> addr_o holds during stalls, exactly 3 transfers (0x000, 0x002, 0x004), done_o after the 3rd.
- Looping and wrap: ADDR_BIT=4, base=0xE, stride=1, cnt_val=3, loop=2 -> addrs E,F,0,E,F,0, loop_o 0→1 with no bubble, last_o only on the 6th beat.
- Zero/edge configs: cnt_val=0 -> DONE next cycle with no valid_o. loop=0 with cnt_val=2 -> exactly 2 beats.
- Abort with simultaneous ready: abort_i=1 and ready_i=1 at beat 2 of 5 -> DONE next cycle, aborted_o=1, cnt_o holds 2, no further valid_o.
- Reset mid-run and ignored start: reset asserted at beat 3 -> IDLE next edge, no done_o, outputs 0. start_i during RUN/DONE -> config unchanged, no restart.
